// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for CPU pipeline stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pipe_pkg;

    // ADDI x0,x0,0: the canonical RISC-V bubble.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // EMPTY: no beat held; BUSY: main slot holds a beat; FULL: main and skid both hold beats.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // One fetched beat at the default 32-bit pc / 32-bit instruction widths.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_beat_t;

endpackage

// File: rtl/pipe_slot.sv
// Single storage slot: valid bit plus payload register with load and clear.
// Latency: load/clear take effect at the next rising edge.
// Backpressure: none; the owner decides when to load or clear.
module pipe_slot
    import cpu_pipe_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Valid bit: reset and clear win over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload only moves on a load; its content is don't-care while invalid.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register for {pc, instr} with valid/ready, optional skid slot, flush and stall counter.
// Latency: 1 cycle input to output when downstream is ready.
// Backpressure: SKID=1 absorbs one extra beat and drives in_ready from state; SKID=0 passes out_ready through.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int               XLEN  = 32,
    parameter int               ILEN  = 32,
    parameter logic [ILEN-1:0]  NOP   = ILEN'(NOP_INSTR),
    parameter bit               SKID  = 1'b1,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [ILEN-1:0]  out_instr,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    localparam int BW = XLEN + ILEN;

    stage_state_t    state;
    stage_state_t    state_nxt;

    logic            accept;
    logic            consume;
    logic [BW-1:0]   in_dat;

    logic            main_vld;
    logic [BW-1:0]   main_dat;
    logic            main_load;
    logic            main_clr;
    logic [BW-1:0]   main_d;

    logic            skid_vld;
    logic [BW-1:0]   skid_dat;
    logic            skid_load;
    logic            skid_clr;

    assign in_dat  = {in_pc, in_instr};
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Main slot always feeds the output; it is the head of the beat order.
    pipe_slot #(.W(BW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (main_clr),
        .load  (main_load),
        .d     (main_d),
        .valid (main_vld),
        .q     (main_dat)
    );

    generate
        if (SKID) begin : g_skid
            // Second slot catches the beat accepted while the main slot is stalled.
            pipe_slot #(.W(BW)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .clear (skid_clr),
                .load  (skid_load),
                .d     (in_dat),
                .valid (skid_vld),
                .q     (skid_dat)
            );
            // Ready depends only on registered state; flush forces it so the flushed beat is drained.
            assign in_ready = (state != FULL) || flush;
        end else begin : g_noskid
            assign skid_vld = 1'b0;
            assign skid_dat = '0;
            // Single entry: room exists if empty or the held beat leaves this cycle.
            assign in_ready = !main_vld || out_ready || flush;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and slot control; flush discards everything held and anything offered.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_d    = in_dat;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (consume && accept) begin
                        main_load = 1'b1;
                    end else if (consume) begin
                        main_clr  = 1'b1;
                        state_nxt = EMPTY;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_load = 1'b1;
                        main_d    = skid_dat;
                        skid_clr  = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // Present a bubble (pc 0, NOP) whenever the main slot is empty.
    always_comb begin
        out_valid = main_vld;
        out_pc    = '0;
        out_instr = NOP;
        if (main_vld) begin
            out_pc    = main_dat[BW-1:ILEN];
            out_instr = main_dat[ILEN-1:0];
        end
    end

    // Stall counter: counts held-but-not-taken cycles, saturates, clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three builds (skid/16-bit cnt, no-skid, skid/4-bit cnt) on shared inputs.
// Latency: checks every cycle against a queue-based reference model.
// Backpressure: driven directly and randomly through out_ready.
module tb_pipe_stage_reg;
    import cpu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        stall_clr = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;

    logic        ir [3];
    logic        ov [3];
    logic [31:0] opc [3];
    logic [31:0] oin [3];
    logic [15:0] sc_a;
    logic [15:0] sc_b;
    logic [3:0]  sc_c;

    int passed = 0;
    int total  = 0;

    // Reference model: per build, an ordered list of held beats and a stall count.
    fetch_beat_t mb [3][2];
    int          mn [3];
    int          mc [3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]), .out_instr(oin[0]),
        .stall_cnt(sc_a), .stall_clr(stall_clr)
    );

    pipe_stage_reg #(.SKID(1'b0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]), .out_instr(oin[1]),
        .stall_cnt(sc_b), .stall_clr(stall_clr)
    );

    pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(ov[2]), .out_ready(out_ready), .out_pc(opc[2]), .out_instr(oin[2]),
        .stall_cnt(sc_c), .stall_clr(stall_clr)
    );

    function automatic int cap(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic int cmax(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    // Room for a new beat as seen from the current inputs.
    function automatic logic exp_rdy(input int i);
        if (cap(i) == 1) return (mn[i] == 0) || out_ready || flush;
        return (mn[i] < 2) || flush;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic compare(input int i);
        logic [15:0] s;
        logic        has;
        s   = (i == 0) ? sc_a : (i == 1) ? sc_b : {12'd0, sc_c};
        has = (mn[i] > 0);
        chk($sformatf("in_ready[%0d]", i),  64'(ir[i]),  64'(exp_rdy(i)));
        chk($sformatf("out_valid[%0d]", i), 64'(ov[i]),  64'(has));
        chk($sformatf("out_pc[%0d]", i),    64'(opc[i]), has ? 64'(mb[i][0].pc) : 64'd0);
        chk($sformatf("out_instr[%0d]", i), 64'(oin[i]), has ? 64'(mb[i][0].instr) : 64'(NOP_INSTR));
        chk($sformatf("stall_cnt[%0d]", i), 64'(s),      64'(mc[i]));
    endtask

    // One cycle: drive inputs after negedge, check, advance the model, move to next negedge.
    task automatic step(input logic v, input logic [31:0] pc, input logic ordy,
                        input logic fl, input logic clr, input logic r);
        logic        acc;
        logic        con;
        fetch_beat_t nb;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = $urandom;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
        rst       = r;
        #1;
        if (!r) begin
            for (int i = 0; i < 3; i++) compare(i);
        end
        nb.pc    = in_pc;
        nb.instr = in_instr;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                mn[i] = 0;
                mc[i] = 0;
            end else begin
                acc = in_valid && exp_rdy(i);
                con = (mn[i] > 0) && out_ready;
                if (stall_clr) mc[i] = 0;
                else if ((mn[i] > 0) && !out_ready && (mc[i] < cmax(i))) mc[i]++;
                if (flush) begin
                    mn[i] = 0;
                end else begin
                    if (con) begin
                        mb[i][0] = mb[i][1];
                        mn[i]--;
                    end
                    if (acc) begin
                        mb[i][mn[i]] = nb;
                        mn[i]++;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mn[i] = 0;
            mc[i] = 0;
        end
        @(negedge clk);

        // Reset for two cycles with a beat offered.
        step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_out_pc", 64'(opc[0]), 64'd0);
        chk("rst_out_instr", 64'(oin[0]), 64'h13);
        chk("rst_stall_cnt", 64'(sc_a), 64'd0);
        chk("rst_in_ready", 64'(ir[0]), 64'd1);

        // Streaming with downstream always ready.
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stream_pc0", 64'(opc[0]), 64'h0);
        chk("stream_vld0", 64'(ov[0]), 64'd1);
        step(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stream_pc4", 64'(opc[0]), 64'h4);
        step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stream_pc8", 64'(opc[0]), 64'h8);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure fills main then skid; 0x108 waits until room appears.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_100", 64'(opc[0]), 64'h100);
        step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_full_rdy", 64'(ir[0]), 64'd0);
        step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_still_100", 64'(opc[0]), 64'h100);
        step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_next_104", 64'(opc[0]), 64'h104);
        chk("bp_stall_cnt", 64'(sc_a), 64'd2);
        step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_next_108", 64'(opc[0]), 64'h108);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush while FULL with a beat offered.
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fl_full_rdy", 64'(ir[0]), 64'd0);
        step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fl_out_valid", 64'(ov[0]), 64'd0);
        chk("fl_out_instr", 64'(oin[0]), 64'h13);
        step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fl_next_beat", 64'(opc[0]), 64'h400);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation of the 4-bit counter, then clear during a stall.
        step(1'b1, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt4", 64'(sc_c), 64'd15);
        chk("sat_cnt16", 64'(sc_a), 64'd20);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_cnt4", 64'(sc_c), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Toggling out_ready with continuous input (no-skid build tracks it combinationally).
        for (int k = 0; k < 20; k++) step(1'b1, 32'h600 + 32'(4 * k), k[0] == 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a stall.
        step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h704, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h708, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_cnt", 64'(sc_a), 64'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0,
                 32'h1000 + 32'(4 * k),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
